iter_shifter: RTL and testbench
===============================

Name: iter_shifter

Overview:
- Multi-cycle shift engine for the datapath: accepts a shift request (value, op, amount 0–15) and shifts one bit position per clock until done.
- Complements the single-position combinational shifter: an arbitrary shift amount is consumed serially over a start/busy/done handshake.
- Sits beside the ALU; the controller FSM issues `start` and waits on `done` before writing back `sout`.

Parameters:
- WIDTH, 16, datapath width in bits.
- AMT_W, 4, width of the shift amount; maximum amount is 2^AMT_W-1.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous active-low reset.
- start  input  1  request strobe; sampled only in IDLE.
- op  input  2  00 = ROR, 01 = LSL, 10 = LSR, 11 = ASR.
- amt  input  AMT_W  number of bit positions to shift.
- in  input  WIDTH  operand.
- sout  output  WIDTH  result register.
- carry  output  1  last bit shifted or rotated out.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse: result valid.

Behaviour:
- Clock and reset (already decided): one clock, `clk`; reset `reset_n` is synchronous, active-low. When `reset_n` is low at a rising edge: state goes to IDLE; sout, carry, done and the counter go to 0; busy is 0.
- State IDLE:
  - On `start` = 1: latch `in` into sout, latch op, load cnt = amt, clear carry.
  - If amt = 0, go to DONE; otherwise go to SHIFT.
  - `start` = 0: stay in IDLE, all registers hold.
- State SHIFT: each edge applies one step to sout and decrements cnt.
  - LSL: sout = {sout[W-2:0], 0}; carry = sout[W-1].
  - LSR: sout = {0, sout[W-1:1]}; carry = sout[0].
  - ASR: sout = {sout[W-1], sout[W-1:1]}; carry = sout[0].
  - ROR: sout = {sout[0], sout[W-1:1]}; carry = sout[0].
  - Go to DONE on the edge where cnt = 1; otherwise stay in SHIFT.
- State DONE: done = 1 for exactly this cycle, busy = 1; next edge goes to IDLE unconditionally.
- Latency:
  - `start` sampled at edge 0; shifts occur at edges 1..amt; done is high in the cycle after edge amt.
  - Start-to-done latency is amt+1 cycles; amt = 0 gives 1 cycle, with sout = in and carry = 0.
- Result hold: sout and carry hold after DONE until the next accepted `start`.
- Start while busy: ignored, with no queuing. Latched op/amt are unaffected by input changes during SHIFT.
- Back-to-back requests: a `start` asserted during DONE is ignored; the earliest next accept is the IDLE cycle after DONE.
- Reset mid-operation: reset in SHIFT or DONE aborts immediately to IDLE with zeroed outputs; no done pulse is issued.
- Arithmetic: no width growth, all WIDTH bits.
  - amt = 15 LSL/LSR leaves only one original bit.
  - ASR saturates to all sign bits.
  - ROR by 15 equals rotate-left by 1.
- Illegal states: encoding is 2 bits with one spare; the spare state decodes to IDLE.

Decomposition:
- Shared package (e.g. `srm_pkg`):
  - typedef enum shift_op_t {ROR = 2'b00, LSL = 2'b01, LSR = 2'b10, ASR = 2'b11}.
  - typedef enum ishift_state_t {IDLE, SHIFT, DONE}.
  - constant WORD_W = 16.
- One natural sub-module, `shift_step`: purely combinational one-position step (op, value in) -> (value out, carry out). It is instantiated once inside iter_shifter, which keeps only the FSM, counter and registers.

Test Plan:
- Reset mid-op: start LSL amt = 8, in = 16'h00FF; pull reset_n low on the 3rd cycle -> next cycle state IDLE, sout = 0, busy = 0, no done pulse; a subsequent request completes normally.
- LSL: in = 16'h0001, op = 01, amt = 4 -> done 5 cycles after start, sout = 16'h0010, carry = 0, busy high for 5 cycles.
- ASR: in = 16'h8000, op = 11, amt = 15 -> sout = 16'hFFFF, carry = 0, done at cycle 16.
  - Then LSR on the same input: sout = 16'h0001.
- ROR: in = 16'h0003, op = 00, amt = 1 -> sout = 16'h8001, carry = 1, done at cycle 2.
- amt = 0: in = 16'hBEEF, any op -> done the cycle after start, sout = 16'hBEEF, carry = 0.
- Start during busy: issue LSR in = 16'hF000, amt = 4; pulse start with op = 01, amt = 1 during SHIFT -> result 16'h0F00, exactly one done pulse; the second start is dropped.

Source files
------------

// File: rtl/iter_shifter_pkg.sv
// ---------------------------------------------------------------------------
// iter_shifter_pkg : shared shift op / state encodings   | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package iter_shifter_pkg;

   localparam int WORD_W = 16;

   typedef enum logic [1:0] {
      ROR = 2'b00,
      LSL = 2'b01,
      LSR = 2'b10,
      ASR = 2'b11
   } shift_op_t;

   // 2'b11 is the spare encoding; it is treated as IDLE.
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } ishift_state_t;

endpackage

`default_nettype wire

// File: rtl/iter_shifter_shift_step.sv
// ---------------------------------------------------------------------------
// shift_step : combinational one-position shift/rotate   | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module shift_step
   import iter_shifter_pkg::*;
#(
   parameter int WIDTH = WORD_W
) (
   input  shift_op_t        op,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             carry
);

   always_comb begin
      dout  = din;
      carry = 1'b0;
      case (op)
         ROR: begin
            dout  = {din[0], din[WIDTH-1:1]};
            carry = din[0];
         end
         LSL: begin
            dout  = {din[WIDTH-2:0], 1'b0};
            carry = din[WIDTH-1];
         end
         LSR: begin
            dout  = {1'b0, din[WIDTH-1:1]};
            carry = din[0];
         end
         ASR: begin
            dout  = {din[WIDTH-1], din[WIDTH-1:1]};
            carry = din[0];
         end
         default: begin
            dout  = din;
            carry = 1'b0;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/iter_shifter.sv
// ---------------------------------------------------------------------------
// iter_shifter : multi-cycle shifter, one bit per clock  | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module iter_shifter
   import iter_shifter_pkg::*;
#(
   parameter int WIDTH = WORD_W,
   parameter int AMT_W = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [AMT_W-1:0] amt,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] sout,
   output logic             carry,
   output logic             busy,
   output logic             done
);

   ishift_state_t    state;
   ishift_state_t    state_nxt;
   shift_op_t        op_q;
   logic [AMT_W-1:0] cnt;
   logic [WIDTH-1:0] step_out;
   logic             step_carry;

   shift_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .op    (op_q),
      .din   (sout),
      .dout  (step_out),
      .carry (step_carry)
   );

   always_comb begin
      state_nxt = IDLE;
      case (state)
         IDLE:    state_nxt = start ? ((amt == '0) ? DONE : SHIFT) : IDLE;
         SHIFT:   state_nxt = (cnt == AMT_W'(1)) ? DONE : SHIFT;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Operands are captured only on an accepted start, so input changes while busy are ignored.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sout  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         op_q  <= ROR;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  sout  <= in;
                  op_q  <= shift_op_t'(op);
                  cnt   <= amt;
                  carry <= 1'b0;
               end
            end
            SHIFT: begin
               sout  <= step_out;
               carry <= step_carry;
               cnt   <= cnt - AMT_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign busy = (state == SHIFT) || (state == DONE);
   assign done = (state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_iter_shifter.sv
// ---------------------------------------------------------------------------
// tb_iter_shifter : scoreboard bench with arithmetic reference model | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_iter_shifter;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [3:0]  amt = 4'd0;
   logic [15:0] in = 16'h0;
   logic [15:0] sout;
   logic        carry;
   logic        busy;
   logic        done;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int issued = 0;
   int done_cnt = 0;

   typedef struct {
      logic [15:0] s;
      logic        c;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   logic [15:0] last_s;
   logic        last_c;

   iter_shifter dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .op      (op),
      .amt     (amt),
      .in      (in),
      .sout    (sout),
      .carry   (carry),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference: whole shift computed in one step from the operation's arithmetic meaning.
   function automatic void ref_shift(input logic [1:0] o, input int a, input logic [15:0] x,
                                     output logic [15:0] r, output logic c);
      logic signed [15:0] sx;
      logic [31:0]        dbl;
      sx  = x;
      dbl = {x, x} >> a;
      r = x;
      c = 1'b0;
      case (o)
         2'b00: begin r = dbl[15:0];          c = (a == 0) ? 1'b0 : r[15];   end
         2'b01: begin r = x << a;             c = (a == 0) ? 1'b0 : x[16-a]; end
         2'b10: begin r = x >> a;             c = (a == 0) ? 1'b0 : x[a-1];  end
         default: begin r = sx >>> a;         c = (a == 0) ? 1'b0 : x[a-1];  end
      endcase
   endfunction

   // Monitor: every done pulse must match the oldest outstanding request.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (done) begin
            done_cnt++;
            if (sb.size() == 0) begin
               chk("spurious_done", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("sout", sout, e.s);
               chk("carry", carry, e.c);
               chk("done_cycle", cyc, e.cyc);
               chk("busy_in_done", busy, 1);
            end
         end
      end
   end

   // Issue one request; optionally pulse a second start at loop step g (ignored by the DUT).
   task automatic req(input logic [1:0] o, input int a, input logic [15:0] x, input int g);
      exp_t e;
      int   bsy;
      bit   seen;
      @(negedge clk);
      op = o; amt = 4'(a); in = x; start = 1'b1;
      ref_shift(o, a, x, e.s, e.c);
      e.cyc = cyc + 1 + a;
      sb.push_back(e);
      issued++;
      last_s = e.s; last_c = e.c;
      bsy = 0; seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (k == 0) begin
            start = 1'b0; op = 2'($urandom); amt = 4'($urandom); in = 16'($urandom);
         end
         if (k == g) begin
            start = 1'b1; op = 2'b01; amt = 4'd1; in = 16'($urandom);
         end else if (k == g + 1) begin
            start = 1'b0;
         end
         if (busy) bsy++;
         if (done) begin seen = 1; break; end
      end
      start = 1'b0;
      if (!seen) chk("done_timeout", 0, 1);
      chk("busy_cycles", bsy, a + 1);
      @(negedge clk);
      chk("idle_after_done", busy, 0);
      chk("hold_sout", sout, last_s);
      chk("hold_carry", carry, last_c);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_sout", sout, 0);
      chk("rst_carry", carry, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      reset_n = 1'b1;

      // Reset mid-operation: no done pulse may appear.
      @(negedge clk);
      op = 2'b01; amt = 4'd8; in = 16'h00FF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("midop_busy", busy, 1);
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      chk("midop_busy_after_rst", busy, 0);
      chk("midop_sout_after_rst", sout, 0);
      chk("midop_done_after_rst", done, 0);
      repeat (3) @(negedge clk);

      req(2'b01, 8, 16'h00FF, -1);
      req(2'b01, 4, 16'h0001, -1);
      req(2'b11, 15, 16'h8000, -1);
      req(2'b10, 15, 16'h8000, -1);
      req(2'b00, 1, 16'h0003, -1);
      req(2'b00, 15, 16'h1234, -1);
      req(2'b01, 15, 16'hFFFF, -1);
      for (int o = 0; o < 4; o++) req(2'(o), 0, 16'hBEEF, -1);
      req(2'b10, 4, 16'hF000, 1);
      req(2'b11, 3, 16'h8421, 3);
      req(2'b01, 0, 16'h5A5A, 0);

      for (int n = 0; n < 40; n++) begin
         int a;
         int g;
         a = int'($urandom_range(0, 15));
         g = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, a)) : -1;
         req(2'($urandom), a, 16'($urandom), g);
      end

      repeat (5) @(negedge clk);
      chk("done_count", done_cnt, issued);
      chk("scoreboard_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
